// File: rtl/alu_result_register_if.sv
// Bus between the ALU/requester, the result register and the downstream consumer.
// Carries capture request, ALU result, handshake, flags and (optionally, ALU_HIST_EN) history read port.
// slave = result register view, master = driver/consumer view.
interface alu_result_register_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic [WIDTH-1:0] ALUout;
    logic [1:0]       Function;
    logic             En;
    logic             Clear;
    logic             Q_ready;
    logic [3:0]       B_fb;
    logic [WIDTH-1:0] Q;
    logic             Q_valid;
    logic             En_ack;
    logic             Carry;
    logic [CNT_W-1:0] OpCount;
`ifdef ALU_HIST_EN
    logic [1:0]       Hist_sel;
    logic [WIDTH-1:0] Hist_out;

    modport slave (
        input  ALUout, Function, En, Clear, Q_ready, Hist_sel,
        output B_fb, Q, Q_valid, En_ack, Carry, OpCount, Hist_out
    );
    modport master (
        output ALUout, Function, En, Clear, Q_ready, Hist_sel,
        input  B_fb, Q, Q_valid, En_ack, Carry, OpCount, Hist_out
    );
`else
    modport slave (
        input  ALUout, Function, En, Clear, Q_ready,
        output B_fb, Q, Q_valid, En_ack, Carry, OpCount
    );
    modport master (
        output ALUout, Function, En, Clear, Q_ready,
        input  B_fb, Q, Q_valid, En_ack, Carry, OpCount
    );
`endif
endinterface

// File: rtl/alu_result_register.sv
// Result register behind the 4-bit ALU: captures ALUout, feeds Q[3:0] back as B, tracks sticky carry and capture count.
// Latency: ALUout+En at edge N is visible on Q after edge N; En_ack pulses the cycle after the capture.
// Backpressure: while FULL and Q_ready=0 nothing is captured; requester holds En until En_ack. Optional history: ALU_HIST_EN.
module alu_result_register #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    alu_result_register_if.slave   bus
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             en_ack_q, en_ack_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             capture;

`ifdef ALU_HIST_EN
    logic [3:0][WIDTH-1:0] hist_q, hist_d;
`endif

    // Capture decision, next state and next values of every register
    always_comb begin
        capture  = 1'b0;
        state_d  = state_q;
        q_d      = q_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        if (bus.Clear) begin
            state_d = EMPTY;
            q_d     = '0;
            carry_d = 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (bus.En) begin
                        capture = 1'b1;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    // Q_ready low is a stall: En is deliberately ignored here
                    if (bus.Q_ready) begin
                        if (bus.En) begin
                            capture = 1'b1;
                        end else begin
                            state_d = EMPTY;
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase
            if (capture) begin
                q_d = bus.ALUout;
                if (bus.Function == 2'b00 && bus.ALUout[4]) begin
                    carry_d = 1'b1;
                end
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
        en_ack_d = capture;
    end

`ifdef ALU_HIST_EN
    // History shifts on every capture only; Clear leaves it alone
    always_comb begin
        hist_d = hist_q;
        if (capture) begin
            hist_d[3] = hist_q[2];
            hist_d[2] = hist_q[1];
            hist_d[1] = hist_q[0];
            hist_d[0] = bus.ALUout;
        end
    end

    // History registers, cleared only by Reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign bus.Hist_out = hist_q[bus.Hist_sel];
`endif

    // FSM state and result/flag registers; Reset dominates everything
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= EMPTY;
            q_q      <= '0;
            en_ack_q <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            en_ack_q <= en_ack_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.Q       = q_q;
    assign bus.B_fb    = q_q[3:0];
    assign bus.Q_valid = (state_q == FULL);
    assign bus.En_ack  = en_ack_q;
    assign bus.Carry   = carry_q;
    assign bus.OpCount = cnt_q;

endmodule

// File: tb/tb_alu_result_register.sv
// Directed bench for alu_result_register: capture expectations go into a scoreboard queue,
// a negedge monitor pops one entry per En_ack pulse and compares Q/B_fb/Carry/OpCount.
// State-only conditions (reset, stall, drain, clear) are checked directly after the edge.
module tb_alu_result_register;

    logic Clock;
    logic Reset;

    alu_result_register_if #(.WIDTH(8), .CNT_W(4)) bus ();

    alu_result_register #(.WIDTH(8), .CNT_W(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] q;
        logic [3:0] b;
        logic       c;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic [7:0] q, input logic c, input logic [3:0] cnt);
        exp_t e;
        e.q   = q;
        e.b   = q[3:0];
        e.c   = c;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    // Monitor: every En_ack pulse must match the oldest outstanding expectation
    always @(negedge Clock) begin
        if (!Reset && bus.En_ack) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got En_ack=1 Q=%0h expected no capture", bus.Q);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_Q",       32'(bus.Q),       32'(e.q));
                chk("sb_B_fb",    32'(bus.B_fb),    32'(e.b));
                chk("sb_Carry",   32'(bus.Carry),   32'(e.c));
                chk("sb_OpCount", 32'(bus.OpCount), 32'(e.cnt));
            end
        end
    end

    initial begin
        logic [7:0] v;
        int         n;
        // Reset held two cycles with a capture request present
        Reset        = 1'b1;
        bus.ALUout   = 8'hFF;
        bus.Function = 2'b00;
        bus.En       = 1'b1;
        bus.Clear    = 1'b0;
        bus.Q_ready  = 1'b0;
`ifdef ALU_HIST_EN
        bus.Hist_sel = 2'd0;
`endif
        cyc();
        cyc();
        chk("rst_Q",       32'(bus.Q),       32'h0);
        chk("rst_B_fb",    32'(bus.B_fb),    32'h0);
        chk("rst_Q_valid", 32'(bus.Q_valid), 32'h0);
        chk("rst_Carry",   32'(bus.Carry),   32'h0);
        chk("rst_OpCount", 32'(bus.OpCount), 32'h0);
        chk("rst_En_ack",  32'(bus.En_ack),  32'h0);

        bus.En = 1'b0;
        Reset  = 1'b0;
        cyc();

        // Basic add capture with ALUout[4]=1 sets carry
        bus.ALUout   = 8'h1A;
        bus.Function = 2'b00;
        bus.En       = 1'b1;
        push(8'h1A, 1'b1, 4'd1);
        cyc();
        bus.En = 1'b0;
        chk("cap_Q_valid", 32'(bus.Q_valid), 32'h1);
        chk("cap_En_ack",  32'(bus.En_ack),  32'h1);

        // Stall: FULL with Q_ready=0, request held for three cycles
        bus.ALUout  = 8'h55;
        bus.En      = 1'b1;
        bus.Q_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_Q",       32'(bus.Q),       32'h1A);
            chk("stall_En_ack",  32'(bus.En_ack),  32'h0);
            chk("stall_OpCount", 32'(bus.OpCount), 32'h1);
        end
        bus.Q_ready = 1'b1;
        push(8'h55, 1'b1, 4'd2);
        cyc();
        bus.En = 1'b0;
        chk("unstall_Q", 32'(bus.Q), 32'h55);

        // Drain: ready with no request empties but keeps Q
        cyc();
        chk("drain_Q_valid", 32'(bus.Q_valid), 32'h0);
        chk("drain_Q",       32'(bus.Q),       32'h55);
        chk("drain_En_ack",  32'(bus.En_ack),  32'h0);

        // Twenty back-to-back OR-flag captures: counter saturates at 15, carry stays set
        bus.Function = 2'b01;
        bus.En       = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            v          = 8'(8'h20 + k);
            n          = (2 + k > 15) ? 15 : 2 + k;
            bus.ALUout = v;
            push(v, 1'b1, 4'(n));
            cyc();
        end
        bus.En = 1'b0;
        chk("sat_OpCount", 32'(bus.OpCount), 32'hF);
        cyc();

        // Clear beats a simultaneous capture request
        bus.ALUout = 8'h07;
        bus.En     = 1'b1;
        bus.Clear  = 1'b1;
        cyc();
        bus.Clear = 1'b0;
        bus.En    = 1'b0;
        chk("clr_Q",       32'(bus.Q),       32'h0);
        chk("clr_Q_valid", 32'(bus.Q_valid), 32'h0);
        chk("clr_Carry",   32'(bus.Carry),   32'h0);
        chk("clr_En_ack",  32'(bus.En_ack),  32'h0);
        chk("clr_OpCount", 32'(bus.OpCount), 32'hF);

        // Non-add capture with ALUout[4]=1 must not set carry
        bus.ALUout   = 8'h10;
        bus.Function = 2'b01;
        bus.En       = 1'b1;
        push(8'h10, 1'b0, 4'd15);
        cyc();
        bus.En = 1'b0;
        chk("or_Carry", 32'(bus.Carry), 32'h0);
        cyc();

`ifdef ALU_HIST_EN
        // History: five captures, newest four visible, survives Clear, wiped by Reset
        bus.En = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            bus.ALUout = 8'(k);
            push(8'(k), 1'b0, 4'd15);
            cyc();
        end
        bus.En = 1'b0;
        cyc();
        for (int s = 0; s < 4; s++) begin
            bus.Hist_sel = 2'(s);
            #1;
            chk("hist", 32'(bus.Hist_out), 32'(5 - s));
        end
        bus.Clear = 1'b1;
        cyc();
        bus.Clear = 1'b0;
        for (int s = 0; s < 4; s++) begin
            bus.Hist_sel = 2'(s);
            #1;
            chk("hist_clr", 32'(bus.Hist_out), 32'(5 - s));
        end
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            bus.Hist_sel = 2'(s);
            #1;
            chk("hist_rst", 32'(bus.Hist_out), 32'h0);
        end
`endif

        // Let the monitor see the last ack, then every expectation must be consumed
        cyc();
        cyc();
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_register.md
Name: alu_result_register

Overview:
- Downstream stage of the 4-bit ALU. Captures the ALU's 8-bit combinational ALUout into a result register.
- Feeds the low nibble of the register back to the ALU B operand, which forms the registered/accumulating ALU.
- Presents the stored result to the downstream consumer (HEX display driver) through a valid/ready handshake.
- Tracks a sticky carry flag and a saturating capture count.

Parameters:
- WIDTH, 8, result register width; must match ALUout width.
- CNT_W, 4, width of the capture counter.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- ALUout  input  WIDTH  combinational result from the ALU.
- Function  input  2  ALU function code, sampled with ALUout (00 add, 01 OR-flag, 10 AND-flag, 11 concat).
- En  input  1  capture request (level).
- Clear  input  1  synchronous clear of result and flags.
- Q_ready  input  1  downstream ready to accept Q.
- B_fb  output  4  Q[3:0], fed back to ALU B operand.
- Q  output  WIDTH  registered result.
- Q_valid  output  1  Q holds an unconsumed result.
- En_ack  output  1  a capture occurred on this edge (registered, one-cycle pulse).
- Carry  output  1  sticky carry from add captures.
- OpCount  output  CNT_W  number of captures since reset, saturating.

Behaviour:
- Reset values: Reset=1 at an edge gives Q=0, B_fb=0, Q_valid=0, En_ack=0, Carry=0, OpCount=0, state EMPTY. Reset overrides every other input.
- Clear: at an edge with Reset=0, Clear=1 gives Q=0, Carry=0, Q_valid=0, state EMPTY, En_ack=0. OpCount is unchanged. Clear overrides En.
- State EMPTY:
  - En=1: capture and go to FULL.
  - En=0: stay in EMPTY.
- State FULL:
  - Q_ready=1, En=1: capture and stay in FULL (back-to-back, no bubble).
  - Q_ready=1, En=0: go to EMPTY, Q_valid=0, Q holds its value.
  - Q_ready=0: stall. En is ignored, there is no capture, and Q is unchanged.
- Capture: Q <= ALUout; En_ack=1 in the following cycle; OpCount increments by 1, saturating at 2^CNT_W-1 (no wrap).
- Carry on capture:
  - If Function==00 and ALUout[4]==1, Carry <= 1.
  - Otherwise Carry holds; it is sticky until Reset or Clear.
- Outputs:
  - Q_valid = (state==FULL).
  - B_fb = Q[3:0] at all times, so the new B operand is visible one cycle after capture.
- Latency: ALUout present with En at edge N gives Q visible after edge N. The ALU output then reflects the new B combinationally within the same cycle.
- Combinational loop: none through this block. Q comes from flops only.
- Stall: during a stall the requester must hold En until it sees En_ack. Captures are never silently dropped.

Optional Feature:
- Macro: ALU_HIST_EN.
- Defined:
  - Adds a 4-entry history shift register of the last four captured values; entry 0 is newest.
  - Adds ports Hist_sel input 2 and Hist_out output WIDTH. Hist_out = hist[Hist_sel], combinational read.
  - Every capture shifts: hist[0] <= ALUout, hist[i] <= hist[i-1].
  - Reset clears all entries to 0. Clear does not affect history.
- Not defined: the history logic and the Hist_sel/Hist_out ports are absent.

Test Plan:
- Reset: assert Reset 2 cycles with En=1, ALUout=8'hFF -> Q=0, Q_valid=0, Carry=0, OpCount=0, En_ack=0.
- Basic capture: EMPTY, ALUout=8'h1A, Function=00, En=1 one cycle -> next cycle Q=8'h1A, B_fb=4'hA, Q_valid=1, En_ack=1, Carry=1, OpCount=1.
- Stall: FULL, Q_ready=0, En=1, ALUout=8'h55 for 3 cycles -> Q stays 8'h1A, En_ack=0, OpCount unchanged. Raise Q_ready -> Q=8'h55 next cycle, En_ack=1.
- Drain and saturation: FULL, Q_ready=1, En=0 -> Q_valid=0, Q unchanged. Then 20 captures with CNT_W=4 -> OpCount=15.
- Clear priority: En=1, Clear=1, ALUout=8'h07 -> Q=0, Q_valid=0, Carry=0, En_ack=0, OpCount unchanged. Function=01 capture of 8'h10 -> Carry stays 0.
- ALU_HIST_EN: capture 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 -> Hist_sel 0..3 reads 05, 04, 03, 02. After Clear the history is retained; after Reset all entries read 0.
